// File: rtl/router_vc_input_buffer_pkg.sv
// Shared NoC router constants and small helpers for the VC input buffer.
package router_vc_input_buffer_pkg;

  localparam int NOC_FLIT_W   = 64;
  localparam int NOC_NUM_VC   = 2;
  localparam int NOC_VC_IDX_W = $clog2(NOC_NUM_VC);

  typedef logic [NOC_FLIT_W-1:0] noc_flit_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/router_vc_fifo.sv
// Single-VC synchronous FIFO: power-of-two depth, wrapping pointers, occupancy count.
module router_vc_fifo
  import router_vc_input_buffer_pkg::*;
#(
  parameter int DATA_W   = NOC_FLIT_W,
  parameter int VC_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PTR_W = $clog2(VC_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [VC_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign full   = (r_count == CNT_W'(VC_DEPTH));
  assign empty  = (r_count == '0);
  // Gating here keeps the count bounded even if a caller ignores full/empty.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/router_vc_input_buffer.sv
// Router input port with NUM_VC virtual-channel FIFOs and a registered output stage.
// Define ROUTER_IBUF_DROP_CNT_EN to add the saturating drop_cnt output.
module router_vc_input_buffer
  import router_vc_input_buffer_pkg::*;
#(
  parameter int DATA_W   = NOC_FLIT_W,
  parameter int NUM_VC   = NOC_NUM_VC,
  parameter int VC_DEPTH = 4,
  parameter int VC_IDX_W = $clog2(NUM_VC)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                send,
  input  logic [VC_IDX_W-1:0] wr_vc,
  input  logic [DATA_W-1:0]   data_in,
  output logic [NUM_VC-1:0]   ready,
  input  logic [VC_IDX_W-1:0] rd_vc,
  input  logic                blocked,
  output logic                out_valid,
  output logic [VC_IDX_W-1:0] out_vc,
  output logic [DATA_W-1:0]   data_out,
`ifdef ROUTER_IBUF_DROP_CNT_EN
  output logic [15:0]         drop_cnt,
`endif
  output logic [NUM_VC-1:0]   empty
);

  logic [NUM_VC-1:0]   w_push;
  logic [NUM_VC-1:0]   w_pop;
  logic [NUM_VC-1:0]   w_full;
  logic [NUM_VC-1:0]   w_empty;
  logic [DATA_W-1:0]   w_head [NUM_VC];
  logic [DATA_W-1:0]   w_head_sel;
  logic                w_rd_empty;
  logic                w_wr_ready;
  logic                w_deq;
  logic                r_out_valid;
  logic [VC_IDX_W-1:0] r_out_vc;
  logic [DATA_W-1:0]   r_data_out;

  // Indices with no matching VC select nothing: they read as not-ready / empty.
  always_comb begin
    w_rd_empty = 1'b1;
    w_head_sel = '0;
    w_wr_ready = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (rd_vc == VC_IDX_W'(v)) begin
        w_rd_empty = w_empty[v];
        w_head_sel = w_head[v];
      end
      if (wr_vc == VC_IDX_W'(v)) begin
        w_wr_ready = !w_full[v];
      end
    end
  end

  assign w_deq = !blocked && !w_rd_empty;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
      assign w_push[gi] = send && (wr_vc == VC_IDX_W'(gi));
      assign w_pop[gi]  = w_deq && (rd_vc == VC_IDX_W'(gi));

      router_vc_fifo #(
        .DATA_W   (DATA_W),
        .VC_DEPTH (VC_DEPTH)
      ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push[gi]),
        .pop   (w_pop[gi]),
        .din   (data_in),
        .full  (w_full[gi]),
        .empty (w_empty[gi]),
        .head  (w_head[gi])
      );
    end
  endgenerate

  assign ready = ~w_full;
  assign empty = w_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_vc    <= '0;
      r_data_out  <= '0;
    end else if (w_deq) begin
      r_out_valid <= 1'b1;
      r_out_vc    <= rd_vc;
      r_data_out  <= w_head_sel;
    end else begin
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_vc    = r_out_vc;
  assign data_out  = r_data_out;

`ifdef ROUTER_IBUF_DROP_CNT_EN
  logic        w_reject;
  logic [15:0] r_drop_cnt;

  assign w_reject = send && !w_wr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (w_reject) begin
      r_drop_cnt <= sat_inc16(r_drop_cnt);
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_router_vc_input_buffer.sv
// Directed self-checking bench for router_vc_input_buffer at default parameters.
module tb_router_vc_input_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        send = 1'b0;
  logic [0:0]  wr_vc = '0;
  logic [63:0] data_in = '0;
  logic [1:0]  ready;
  logic [0:0]  rd_vc = '0;
  logic        blocked = 1'b0;
  logic        out_valid;
  logic [0:0]  out_vc;
  logic [63:0] data_out;
  logic [1:0]  empty;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  router_vc_input_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .send      (send),
    .wr_vc     (wr_vc),
    .data_in   (data_in),
    .ready     (ready),
    .rd_vc     (rd_vc),
    .blocked   (blocked),
    .out_valid (out_valid),
    .out_vc    (out_vc),
    .data_out  (data_out),
`ifdef ROUTER_IBUF_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .empty     (empty)
  );

`ifndef ROUTER_IBUF_DROP_CNT_EN
  assign drop_cnt = '0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [0:0] vc, input logic [63:0] d);
    send = 1'b1; wr_vc = vc; data_in = d;
    step();
    send = 1'b0;
    $display("write vc=%0d data=%h ready=%b empty=%b", vc, d, ready, empty);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    n_checks++;
    if (ready !== 2'b11) begin n_fails++; $display("FAIL reset_ready got %b exp 11", ready); end
    n_checks++;
    if (empty !== 2'b11) begin n_fails++; $display("FAIL reset_empty got %b exp 11", empty); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_checks++;
    if (data_out !== 64'h0) begin n_fails++; $display("FAIL reset_data got %h exp 0", data_out); end
`ifdef ROUTER_IBUF_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 16'h0) begin n_fails++; $display("FAIL reset_drop got %h exp 0", drop_cnt); end
`endif
  endtask

  task automatic test_latency();
    rd_vc = 1'b0; blocked = 1'b0;
    put(1'b0, 64'hA);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fails++; $display("FAIL lat_nobypass got %b exp 0", out_valid); end
    n_checks++;
    if (empty !== 2'b10) begin n_fails++; $display("FAIL lat_empty got %b exp 10", empty); end
    step();
    $display("read valid=%b vc=%0d data=%h", out_valid, out_vc, data_out);
    n_checks++;
    if ({out_valid, out_vc, data_out} !== {1'b1, 1'b0, 64'hA})
      begin n_fails++; $display("FAIL lat_out got v=%b vc=%0d d=%h exp v=1 vc=0 d=a", out_valid, out_vc, data_out); end
    step();
    n_checks++;
    if ({out_valid, data_out} !== {1'b0, 64'h0})
      begin n_fails++; $display("FAIL lat_idle got v=%b d=%h exp v=0 d=0", out_valid, data_out); end
  endtask

  task automatic test_fill_block();
    blocked = 1'b1; rd_vc = 1'b1;
    for (int i = 1; i <= 4; i++) put(1'b1, 64'(i));
    n_checks++;
    if (ready !== 2'b01) begin n_fails++; $display("FAIL full_ready got %b exp 01", ready); end
    n_checks++;
    if (empty !== 2'b01) begin n_fails++; $display("FAIL full_empty got %b exp 01", empty); end
    put(1'b1, 64'h5);
    n_checks++;
    if ({ready, out_valid} !== {2'b01, 1'b0})
      begin n_fails++; $display("FAIL drop_state got ready=%b v=%b exp ready=01 v=0", ready, out_valid); end
`ifdef ROUTER_IBUF_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 16'd1) begin n_fails++; $display("FAIL drop_cnt1 got %0d exp 1", drop_cnt); end
`endif
    blocked = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      $display("read valid=%b vc=%0d data=%h", out_valid, out_vc, data_out);
      n_checks++;
      if ({out_valid, out_vc, data_out} !== {1'b1, 1'b1, 64'(i)})
        begin n_fails++; $display("FAIL drain_%0d got v=%b vc=%0d d=%h exp v=1 vc=1 d=%h", i, out_valid, out_vc, data_out, 64'(i)); end
    end
    step();
    n_checks++;
    if ({out_valid, empty, ready} !== {1'b0, 2'b11, 2'b11})
      begin n_fails++; $display("FAIL drain_end got v=%b e=%b r=%b exp v=0 e=11 r=11", out_valid, empty, ready); end
  endtask

  task automatic test_same_cycle();
    logic [63:0] exp_q[$];
    blocked = 1'b1; rd_vc = 1'b0;
    put(1'b0, 64'h20); put(1'b0, 64'h21);
    blocked = 1'b0;
    put(1'b0, 64'h22);
    exp_q = '{64'h20, 64'h21, 64'h22};
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      n_checks++;
      if ({out_valid, data_out} !== {1'b1, exp_q[i]})
        begin n_fails++; $display("FAIL same_%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, data_out, exp_q[i]); end
    end
    step();
    n_checks++;
    if ({out_valid, empty} !== {1'b0, 2'b11})
      begin n_fails++; $display("FAIL same_end got v=%b e=%b exp v=0 e=11", out_valid, empty); end
    // Full VC: the write is rejected even though the same cycle dequeues.
    blocked = 1'b1;
    for (int i = 0; i < 4; i++) put(1'b0, 64'h30 + 64'(i));
    blocked = 1'b0;
    put(1'b0, 64'h34);
    n_checks++;
    if ({out_valid, data_out} !== {1'b1, 64'h30})
      begin n_fails++; $display("FAIL fullsame got v=%b d=%h exp v=1 d=30", out_valid, data_out); end
`ifdef ROUTER_IBUF_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 16'd2) begin n_fails++; $display("FAIL drop_cnt2 got %0d exp 2", drop_cnt); end
`endif
    for (int i = 1; i <= 3; i++) begin
      step();
      n_checks++;
      if ({out_valid, data_out} !== {1'b1, 64'h30 + 64'(i)})
        begin n_fails++; $display("FAIL fulldrain_%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, data_out, 64'h30 + 64'(i)); end
    end
    step();
    n_checks++;
    if ({out_valid, empty} !== {1'b0, 2'b11})
      begin n_fails++; $display("FAIL fulldrain_end got v=%b e=%b exp v=0 e=11", out_valid, empty); end
  endtask

  task automatic test_interleave();
    blocked = 1'b0;
    rd_vc = 1'b1; put(1'b0, 64'h10);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fails++; $display("FAIL il_first got v=%b exp 0", out_valid); end
    rd_vc = 1'b0; put(1'b1, 64'h11);
    n_checks++;
    if ({out_valid, out_vc, data_out} !== {1'b1, 1'b0, 64'h10})
      begin n_fails++; $display("FAIL il_vc0 got v=%b vc=%0d d=%h exp v=1 vc=0 d=10", out_valid, out_vc, data_out); end
    rd_vc = 1'b1; put(1'b1, 64'h0);
    n_checks++;
    if ({out_valid, out_vc, data_out} !== {1'b1, 1'b1, 64'h11})
      begin n_fails++; $display("FAIL il_vc1 got v=%b vc=%0d d=%h exp v=1 vc=1 d=11", out_valid, out_vc, data_out); end
    step();
    n_checks++;
    if ({out_valid, out_vc, data_out} !== {1'b1, 1'b1, 64'h0})
      begin n_fails++; $display("FAIL zero_flit got v=%b vc=%0d d=%h exp v=1 vc=1 d=0", out_valid, out_vc, data_out); end
    rd_vc = 1'b0;
    step();
    n_checks++;
    if ({out_valid, empty} !== {1'b0, 2'b11})
      begin n_fails++; $display("FAIL il_end got v=%b e=%b exp v=0 e=11", out_valid, empty); end
  endtask

  task automatic test_reset_mid();
    blocked = 1'b1; rd_vc = 1'b0;
    for (int i = 0; i < 3; i++) put(1'b0, 64'h40 + 64'(i));
    blocked = 1'b0;
    step();
    n_checks++;
    if ({out_valid, data_out} !== {1'b1, 64'h40})
      begin n_fails++; $display("FAIL pre_reset got v=%b d=%h exp v=1 d=40", out_valid, data_out); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if ({empty, ready, out_valid, data_out} !== {2'b11, 2'b11, 1'b0, 64'h0})
      begin n_fails++; $display("FAIL mid_reset got e=%b r=%b v=%b d=%h exp e=11 r=11 v=0 d=0", empty, ready, out_valid, data_out); end
`ifdef ROUTER_IBUF_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 16'd0) begin n_fails++; $display("FAIL mid_reset_drop got %0d exp 0", drop_cnt); end
`endif
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fails++; $display("FAIL post_reset_%0d got v=%b exp 0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill_block();
    test_same_cycle();
    test_interleave();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
